// File: rtl/mc_ctrl_if.sv
// Handshake bundle between the multicycle controller and its datapath.
// The datapath drives Op/Funct/Zero; the controller drives everything else.
interface mc_ctrl_if;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        PCWriteEn;
  logic        PCWr;
  logic        JUMP;
  logic        IRWr;
  logic        RFWr;
  logic        DMWr;
  logic [1:0]  ALUOp;
  logic        ALUSrc;
  logic        RegDst;
  logic        MemToReg;
  logic [3:0]  State;
  logic        IllegalOp;
  logic [31:0] InstrCnt;

  modport master (
    output Op, Funct, Zero,
    input  PCWriteEn, PCWr, JUMP, IRWr, RFWr, DMWr, ALUOp, ALUSrc, RegDst, MemToReg,
    input  State, IllegalOp, InstrCnt
  );

  modport slave (
    input  Op, Funct, Zero,
    output PCWriteEn, PCWr, JUMP, IRWr, RFWr, DMWr, ALUOp, ALUSrc, RegDst, MemToReg,
    output State, IllegalOp, InstrCnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset controller: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, with a sticky illegal-op flag and a retired-instruction counter.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.slave    bus
);

  typedef enum logic [3:0] {
    StFetch = 4'd0,
    StDcd   = 4'd1,
    StExe   = 4'd2,
    StMa    = 4'd3,
    StMrd   = 4'd4,
    StMwr   = 4'd5,
    StWb    = 4'd6,
    StBr    = 4'd7,
    StJmp   = 4'd8
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;

  state_e      r_state, w_state_d;
  logic [5:0]  r_op, r_funct;
  logic        r_m2r;
  logic        r_ill;
  logic [31:0] r_cnt;

  logic w_dcd_r, w_dcd_alu, w_dcd_mem, w_dcd_beq, w_dcd_j, w_dcd_ill, w_retire;

  // Decode of the live opcode; only consulted while in DCD.
  assign w_dcd_r   = (bus.Op == OpRtype) && (bus.Funct == FnAddu || bus.Funct == FnSubu);
  assign w_dcd_alu = w_dcd_r || bus.Op == OpOri || bus.Op == OpLui;
  assign w_dcd_mem = (bus.Op == OpLw) || (bus.Op == OpSw);
  assign w_dcd_beq = (bus.Op == OpBeq);
  assign w_dcd_j   = (bus.Op == OpJ);
  assign w_dcd_ill = !(w_dcd_alu || w_dcd_mem || w_dcd_beq || w_dcd_j);
  assign w_retire  = (r_state == StMwr) || (r_state == StWb) ||
                     (r_state == StBr)  || (r_state == StJmp);

  always_comb begin
    w_state_d = StFetch;
    unique case (r_state)
      StFetch: w_state_d = StDcd;
      StDcd: begin
        if (w_dcd_alu)      w_state_d = StExe;
        else if (w_dcd_mem) w_state_d = StMa;
        else if (w_dcd_beq) w_state_d = StBr;
        else if (w_dcd_j)   w_state_d = StJmp;
        else                w_state_d = StFetch;
      end
      StExe:   w_state_d = StWb;
      StMa:    w_state_d = (r_op == OpLw) ? StMrd : StMwr;
      StMrd:   w_state_d = StWb;
      default: w_state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFetch;
      r_op    <= '0;
      r_funct <= '0;
      r_m2r   <= 1'b0;
      r_ill   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StDcd) begin
        r_op    <= bus.Op;
        r_funct <= bus.Funct;
        if (w_dcd_ill) r_ill <= 1'b1;
      end
      r_m2r <= (r_state == StMrd);
      if (w_retire) r_cnt <= r_cnt + 32'd1;
    end
  end

  // Outputs are held idle while rst is high so an aborted WB/MWR cannot write.
  always_comb begin
    bus.PCWriteEn = 1'b0;
    bus.PCWr      = 1'b0;
    bus.JUMP      = 1'b1;
    bus.IRWr      = 1'b0;
    bus.RFWr      = 1'b0;
    bus.DMWr      = 1'b0;
    bus.ALUOp     = 2'b00;
    bus.ALUSrc    = 1'b0;
    bus.RegDst    = 1'b0;
    bus.MemToReg  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        StFetch: begin
          bus.IRWr      = 1'b1;
          bus.PCWriteEn = 1'b1;
        end
        StExe: begin
          if (r_op == OpRtype && r_funct == FnSubu) bus.ALUOp = 2'b01;
          else if (r_op == OpOri)                  bus.ALUOp = 2'b10;
          else if (r_op == OpLui)                  bus.ALUOp = 2'b11;
          bus.ALUSrc = (r_op == OpOri) || (r_op == OpLui);
        end
        StMa:  bus.ALUSrc = 1'b1;
        StMwr: bus.DMWr   = 1'b1;
        StWb: begin
          bus.RFWr     = 1'b1;
          bus.RegDst   = (r_op == OpRtype);
          bus.MemToReg = r_m2r;
        end
        StBr: begin
          bus.ALUOp = 2'b01;
          bus.PCWr  = bus.Zero;
        end
        StJmp:   bus.JUMP = 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.State     = r_state;
  assign bus.IllegalOp = r_ill;
  assign bus.InstrCnt  = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: an instruction-level model predicts the state path and
// the per-cycle control outputs, and a negedge process compares them against the DUT.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef enum int {KAddu, KSubu, KOri, KLui, KLw, KSw, KBeq, KJ, KIll} kind_e;

  int total = 0;
  int bad   = 0;

  logic  chk_en = 1'b0;
  int    e_state;
  kind_e e_kind;
  logic  e_zero;
  int    e_cnt;
  logic  e_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: return (fn == 6'b100001) ? KAddu : (fn == 6'b100011) ? KSubu : KIll;
      6'b001101: return KOri;
      6'b001111: return KLui;
      6'b100011: return KLw;
      6'b101011: return KSw;
      6'b000100: return KBeq;
      6'b000010: return KJ;
      default:   return KIll;
    endcase
  endfunction

  // Per-cycle expectations from the instruction-level behaviour.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0] alu;
      alu = 2'b00;
      if (e_state == 2) alu = (e_kind == KSubu) ? 2'd1 : (e_kind == KOri) ? 2'd2 :
                              (e_kind == KLui) ? 2'd3 : 2'd0;
      if (e_state == 7) alu = 2'd1;
      chk("State",     32'(bus.State),     32'(e_state));
      chk("PCWriteEn", 32'(bus.PCWriteEn), 32'(e_state == 0));
      chk("IRWr",      32'(bus.IRWr),      32'(e_state == 0));
      chk("RFWr",      32'(bus.RFWr),      32'(e_state == 6));
      chk("DMWr",      32'(bus.DMWr),      32'(e_state == 5));
      chk("PCWr",      32'(bus.PCWr),      32'(e_state == 7 && e_zero));
      chk("JUMP",      32'(bus.JUMP),      32'(e_state != 8));
      chk("ALUOp",     32'(bus.ALUOp),     32'(alu));
      chk("ALUSrc",    32'(bus.ALUSrc),
          32'((e_state == 2 && (e_kind == KOri || e_kind == KLui)) || e_state == 3));
      chk("RegDst",    32'(bus.RegDst),
          32'(e_state == 6 && (e_kind == KAddu || e_kind == KSubu)));
      chk("MemToReg",  32'(bus.MemToReg),  32'(e_state == 6 && e_kind == KLw));
      chk("IllegalOp", 32'(bus.IllegalOp), 32'(e_ill));
      chk("InstrCnt",  bus.InstrCnt,       32'(e_cnt));
    end
  end

  // Starts in a FETCH cycle (just after a posedge) and ends in the next FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    int path[$];
    kind_e k;
    k = classify(op, fn);
    case (k)
      KLw:     path = '{0, 1, 3, 4, 6};
      KSw:     path = '{0, 1, 3, 5};
      KBeq:    path = '{0, 1, 7};
      KJ:      path = '{0, 1, 8};
      KIll:    path = '{0, 1};
      default: path = '{0, 1, 2, 6};
    endcase
    bus.Op = op; bus.Funct = fn; bus.Zero = zero;
    e_kind = k; e_zero = zero;
    for (int i = 0; i < path.size(); i++) begin
      e_state = path[i];
      chk_en  = 1'b1;
      @(posedge clk);
      #1;
      // Opcode is latched in DCD; scribble it afterwards.
      if (i == 1) begin bus.Op = 6'h3f; bus.Funct = 6'h3f; end
    end
    chk_en = 1'b0;
    if (k == KIll) e_ill = 1'b1;
    else           e_cnt++;
  endtask

  initial begin
    bus.Op = '0; bus.Funct = '0; bus.Zero = 1'b0;
    e_cnt = 0; e_ill = 1'b0; e_state = 0; e_kind = KAddu; e_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_State",     32'(bus.State),     32'd0);
    chk("rst_PCWriteEn", 32'(bus.PCWriteEn), 32'd0);
    chk("rst_IRWr",      32'(bus.IRWr),      32'd0);
    chk("rst_JUMP",      32'(bus.JUMP),      32'd1);
    chk("rst_InstrCnt",  bus.InstrCnt,       32'd0);
    rst = 1'b0;

    run_instr(6'b000000, 6'b100001, 1'b0);
    chk("addu_cnt", bus.InstrCnt, 32'd1);
    run_instr(6'b000000, 6'b100011, 1'b0);
    run_instr(6'b001101, 6'b000000, 1'b0);
    run_instr(6'b001111, 6'b000000, 1'b1);
    run_instr(6'b100011, 6'b000000, 1'b0);
    run_instr(6'b101011, 6'b000000, 1'b0);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    run_instr(6'b000010, 6'b000000, 1'b0);
    chk("pre_ill_cnt", bus.InstrCnt, 32'd9);
    run_instr(6'b111111, 6'b000000, 1'b0);
    chk("ill_state", 32'(bus.State),     32'd0);
    chk("ill_flag",  32'(bus.IllegalOp), 32'd1);
    chk("ill_cnt",   bus.InstrCnt,       32'd9);
    run_instr(6'b000000, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b100001, 1'b0);
    chk("sticky_ill", 32'(bus.IllegalOp), 32'd1);
    chk("cnt_10",     bus.InstrCnt,       32'd10);

    // Abort an addu in WB with an asynchronous reset pulse.
    bus.Op = 6'b000000; bus.Funct = 6'b100001;
    repeat (3) begin @(posedge clk); #1; end
    chk("wb_State", 32'(bus.State), 32'd6);
    chk("wb_RFWr",  32'(bus.RFWr),  32'd1);
    rst = 1'b1;
    #1;
    chk("abort_RFWr",      32'(bus.RFWr),      32'd0);
    chk("abort_State",     32'(bus.State),     32'd0);
    chk("abort_InstrCnt",  bus.InstrCnt,       32'd0);
    chk("abort_IllegalOp", 32'(bus.IllegalOp), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; e_cnt = 0; e_ill = 1'b0;
    run_instr(6'b000000, 6'b100001, 1'b0);
    chk("post_rst_cnt", bus.InstrCnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning (clock and reset first).
- clk  in  1  single system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- Op  in  6  IR[31:26] opcode
- Funct  in  6  IR[5:0] function field
- Zero  in  1  ALU zero flag, valid in BR state
- PCWriteEn  out  1  PC <= PC+4
- PCWr  out  1  with JUMP=1: PC <= NPC (taken beq)
- JUMP  out  1  with PCWr=0: 1 = hold PC; 0 = PC <= {PC[31:28],IR[25:0],00}
- IRWr  out  1  latch instruction register
- RFWr  out  1  register-file write
- DMWr  out  1  data-memory write
- ALUOp  out  2  00 add, 01 sub, 10 or, 11 lui-shift
- ALUSrc  out  1  0 = register B, 1 = extended immediate
- RegDst  out  1  0 = rt, 1 = rd
- MemToReg  out  1  1 = write-back from data memory
- State  out  4  current state code (debug)
- IllegalOp  out  1  sticky: undecodable instruction seen
- InstrCnt  out  32  retired-instruction counter

Function
REQ-002 Decoded set SHALL be addu (Op 000000, Funct 100001), subu (000000/100011), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010; all else illegal.
REQ-003 States and codes SHALL be FETCH=0, DCD=1, EXE=2, MA=3, MRD=4, MWR=5, WB=6, BR=7, JMP=8; codes 9-15 SHALL go to FETCH next cycle.
REQ-004 Outputs SHALL be Moore (function of State only, except PCWr in BR); idle values: PCWriteEn=0, PCWr=0, JUMP=1, IRWr=0, RFWr=0, DMWr=0, others 0.
REQ-005 FETCH: IRWr=1, PCWriteEn=1; next DCD.
REQ-006 DCD: no writes; next EXE for addu/subu/ori/lui, MA for lw/sw, BR for beq, JMP for j; illegal -> FETCH and IllegalOp set to 1.
REQ-007 EXE: ALUOp add/sub/or/lui per opcode; ALUSrc=1 for ori/lui; next WB.
REQ-008 MA: ALUOp=00, ALUSrc=1; next MRD for lw, MWR for sw.
REQ-009 MRD: next WB; MWR: DMWr=1, next FETCH.
REQ-010 WB: RFWr=1; RegDst=1 for R-type else 0; MemToReg=1 only when entered from MRD (held in a 1-bit register); next FETCH.
REQ-011 BR: ALUOp=01; PCWr=Zero, JUMP=1; next FETCH.
REQ-012 JMP: PCWr=0, JUMP=0; next FETCH.
REQ-013 PCWr=0 with JUMP=0 SHALL occur only in JMP; no two PC-modifying encodings SHALL be active in one cycle.
REQ-014 Op/Funct SHALL be sampled only in DCD and held in internal registers for later states; changes elsewhere SHALL have no effect.
REQ-015 InstrCnt SHALL increment by 1 on each transition into FETCH from MWR, WB, BR or JMP; it wraps 0xFFFFFFFF -> 0; illegal-op returns do not count.
REQ-016 Instruction latency in cycles SHALL be: addu/subu/ori/lui 4, lw 5, sw 4, beq 3, j 3.

Reset
REQ-017 While rst=1, State SHALL be FETCH, all outputs at idle values (REQ-004, including PCWriteEn=0 and IRWr=0), IllegalOp=0, InstrCnt=0, and internal Op/MemToReg registers 0.
REQ-018 rst asserted mid-instruction SHALL abort it immediately (asynchronously), with no partial RFWr/DMWr after assertion.
REQ-019 First FETCH outputs SHALL appear in the cycle after rst deasserts.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then Op=000000/Funct=100001 held -> states 0,1,2,6,0; RFWr=1 and RegDst=1 in state 6; InstrCnt=1.
- lw (100011) -> states 0,1,3,4,6; MemToReg=1 and RFWr=1 in WB; sw (101011) -> 0,1,3,5 with DMWr=1 only in state 5.
- beq with Zero=1 -> PCWr=1, JUMP=1 in state 7; with Zero=0 -> PCWr=0; both return to FETCH.
- j (000010) -> state 8 with PCWr=0, JUMP=0 for exactly one cycle; PCWriteEn=1 only in FETCH.
- Op=111111 -> IllegalOp=1 after DCD, FETCH next, InstrCnt unchanged; IllegalOp stays 1 until rst.
- rst pulsed during state 6 -> RFWr drops to 0 at once; State=0, InstrCnt=0.
